// File: rtl/vga_fb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_fb_pkg: frame-buffer geometry and default VGA timing values |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package vga_fb_pkg;
  localparam int FB_W  = 160;
  localparam int FB_H  = 120;
  localparam int AW    = 15;
  localparam int RGB_W = 12;
  localparam int ROW_W = 7;
  localparam int COL_W = 8;

  localparam int DEF_SCREEN_X = 640;
  localparam int DEF_SCREEN_Y = 480;
  localparam int DEF_H_LAST   = 800;
  localparam int DEF_V_LAST   = 525;
endpackage
`default_nettype wire

// File: rtl/vga_fb_addr_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_fb_addr_gen: row*160+col via shift-add, purely combinational |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = AW
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_row = ADDR_W'(row);
  assign w_col = ADDR_W'(col);
  // 160 = 128 + 32
  assign addr  = (w_row << 7) + (w_row << 5) + w_col;
endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_fb_arbiter: display-priority arbiter for a 4x-scaled VGA frame  |
// | buffer. Define VGA_FB_ARB_ERRCNT_EN to enable the dropped-write     |
// | counter. Rev 1.0                                                    |
// +--------------------------------------------------------------------+
module vga_fb_arbiter #(
  parameter int SCREEN_X = vga_fb_pkg::DEF_SCREEN_X,
  parameter int SCREEN_Y = vga_fb_pkg::DEF_SCREEN_Y,
  parameter int H_LAST   = vga_fb_pkg::DEF_H_LAST,
  parameter int V_LAST   = vga_fb_pkg::DEF_V_LAST,
  parameter int FB_W     = vga_fb_pkg::FB_W,
  parameter int FB_H     = vga_fb_pkg::FB_H,
  parameter int AW       = vga_fb_pkg::AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   posX,
  input  logic [8:0]                   posY,
  output logic [vga_fb_pkg::RGB_W-1:0] pix_out,
  input  logic                         wr_req,
  input  logic [AW-1:0]                wr_addr,
  input  logic [vga_fb_pkg::RGB_W-1:0] wr_data,
  output logic                         wr_gnt,
  output logic [AW-1:0]                mem_addr,
  output logic                         mem_we,
  output logic [vga_fb_pkg::RGB_W-1:0] mem_wdata,
  input  logic [vga_fb_pkg::RGB_W-1:0] mem_rdata,
  output logic                         frame_start,
  output logic [7:0]                   err_cnt
);
  import vga_fb_pkg::*;

  localparam logic [9:0]    c_xDispLim  = 10'(SCREEN_X - 4);
  localparam logic [9:0]    c_xPrefetch = 10'(H_LAST - 2);
  localparam logic [9:0]    c_yScreen   = 10'(SCREEN_Y);
  localparam logic [9:0]    c_yLast     = 10'(V_LAST);
  localparam logic [AW-1:0] c_fbSize    = AW'(FB_W * FB_H);

  logic [9:0]       w_y;
  logic [9:0]       w_yNext;
  logic             w_dispDec;
  logic             w_pfDec;
  logic [ROW_W-1:0] w_pfRow;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [AW-1:0]    w_rdAddr;
  logic             w_rdDec;
  logic             w_wrOk;
  logic [1:0]       r_rdPipe;

  // posY is widened so the wrap compare against V_LAST is exact
  assign w_y       = {1'b0, posY};
  assign w_yNext   = w_y + 10'd1;
  assign w_dispDec = (w_y < c_yScreen) && (posX < c_xDispLim) && (posX[1:0] == 2'd1);

  always_comb begin
    w_pfDec = 1'b0;
    w_pfRow = '0;
    if (posX == c_xPrefetch) begin
      if (w_y == c_yLast) begin
        w_pfDec = 1'b1;
      end else if (w_yNext < c_yScreen) begin
        w_pfDec = 1'b1;
        w_pfRow = w_yNext[8:2];
      end
    end
  end

  // Display reads fetch one group ahead; prefetch fetches column 0
  assign w_row = w_dispDec ? posY[8:2] : w_pfRow;
  assign w_col = w_dispDec ? (posX[9:2] + 8'd1) : '0;

  vga_fb_addr_gen #(
    .ADDR_W (AW)
  ) u_addrGen (
    .row  (w_row),
    .col  (w_col),
    .addr (w_rdAddr)
  );

  assign w_rdDec = w_dispDec | w_pfDec;
  assign wr_gnt  = rst & wr_req & ~w_rdDec;
  assign w_wrOk  = (wr_addr < c_fbSize);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_out     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      frame_start <= 1'b0;
      r_rdPipe    <= 2'b00;
    end else begin
      frame_start <= (posX == 10'd0) && (posY == 9'd0);
      r_rdPipe    <= {r_rdPipe[0], w_rdDec};
      if (r_rdPipe[1]) begin
        pix_out <= mem_rdata;
      end
      mem_we <= 1'b0;
      if (w_rdDec) begin
        mem_addr <= w_rdAddr;
      end else if (wr_gnt && w_wrOk) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

`ifdef VGA_FB_ARB_ERRCNT_EN
  logic [7:0] r_errCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_errCnt <= 8'd0;
    end else if (wr_gnt && !w_wrOk && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign err_cnt = r_errCnt;
`else
  assign err_cnt = 8'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_fb_arbiter: randomized line sweeps against a behavioural     |
// | model of the arbiter, with a RAM model attached. Rev 1.0            |
// +--------------------------------------------------------------------+
module tb_vga_fb_arbiter;
  localparam int SCREEN_X = 640;
  localparam int SCREEN_Y = 480;
  localparam int H_LAST   = 800;
  localparam int V_LAST   = 525;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int MEM_SZ   = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic [11:0] pixOut;
  logic        wrReq;
  logic [14:0] wrAddr;
  logic [11:0] wrData;
  logic        wrGnt;
  logic [14:0] memAddr;
  logic        memWe;
  logic [11:0] memWdata;
  logic [11:0] memRdata = 12'd0;
  logic        frameStart;
  logic [7:0]  errCnt;

  logic [11:0] ram    [MEM_SZ];
  logic [11:0] refRam [MEM_SZ];

  int nChecks = 0;
  int nFails  = 0;

  // model state: values the registered outputs should hold now
  logic [11:0] expPix, expWdata, p1d, p2d;
  logic [14:0] expAddr;
  logic        expWe, expFs, p1v, p2v;
  int          drops;

  vga_fb_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .posX        (posX),
    .posY        (posY),
    .pix_out     (pixOut),
    .wr_req      (wrReq),
    .wr_addr     (wrAddr),
    .wr_data     (wrData),
    .wr_gnt      (wrGnt),
    .mem_addr    (memAddr),
    .mem_we      (memWe),
    .mem_wdata   (memWdata),
    .mem_rdata   (memRdata),
    .frame_start (frameStart),
    .err_cnt     (errCnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWe) ram[memAddr] <= memWdata;
    memRdata <= ram[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s posX=%0d posY=%0d obs=%0h exp=%0h", tag, posX, posY, obs, exp);
    end
  endtask

  function automatic int expErr();
`ifdef VGA_FB_ARB_ERRCNT_EN
    return (drops > 255) ? 255 : drops;
`else
    return 0;
`endif
  endfunction

  task automatic step(input int x, input int y, input logic r, input logic req,
                      input int a, input logic [11:0] d);
    bit dispDec, pfDec, dec, gnt;
    int nrow, addr;
    @(posedge clk);
    #1;
    posX   = 10'(x);
    posY   = 9'(y);
    rst    = r;
    wrReq  = req;
    wrAddr = 15'(a);
    wrData = d;
    dispDec = (y < SCREEN_Y) && (x < SCREEN_X - 4) && (x % 4 == 1);
    pfDec   = 1'b0;
    nrow    = 0;
    if (x == H_LAST - 2) begin
      if (y == V_LAST) begin
        pfDec = 1'b1;
      end else if (y + 1 < SCREEN_Y) begin
        pfDec = 1'b1;
        nrow  = (y + 1) / 4;
      end
    end
    addr = dispDec ? ((y / 4) * FB_W + x / 4 + 1) : (nrow * FB_W);
    dec  = dispDec || pfDec;
    gnt  = r && req && !dec;
    @(negedge clk);
    chk("wr_gnt", 32'(wrGnt), 32'(gnt));
    chk("mem_addr", 32'(memAddr), 32'(expAddr));
    chk("mem_we", 32'(memWe), 32'(expWe));
    chk("mem_wdata", 32'(memWdata), 32'(expWdata));
    chk("frame_start", 32'(frameStart), 32'(expFs));
    chk("err_cnt", 32'(errCnt), 32'(expErr()));
    chk("pix_out", 32'(pixOut), 32'(expPix));
    if (!r) begin
      expPix = '0; expAddr = '0; expWe = 1'b0; expWdata = '0; expFs = 1'b0;
      drops = 0; p1v = 1'b0; p2v = 1'b0;
    end else begin
      expFs = (x == 0) && (y == 0);
      if (p2v) expPix = p2d;
      p2v = p1v;
      p2d = p1d;
      p1v = dec;
      p1d = dec ? refRam[addr] : 12'd0;
      expWe = 1'b0;
      if (dec) begin
        expAddr = 15'(addr);
      end else if (gnt) begin
        if (a < FB_W * FB_H) begin
          expWe    = 1'b1;
          expAddr  = 15'(a);
          expWdata = d;
          refRam[a] = d;
        end else begin
          drops++;
        end
      end
    end
  endtask

  // mode 0: random writes, 1: out-of-range writes held, 2: 0x10/0xABC held early in line
  task automatic runLine(input int y, input int rstFrom, input int rstTo, input int mode);
    logic r, req;
    int a;
    logic [11:0] d;
    for (int x = 0; x <= H_LAST; x++) begin
      r = !(x >= rstFrom && x <= rstTo);
      if (mode == 1) begin
        req = 1'b1; a = FB_W * FB_H; d = 12'(x);
      end else if (mode == 2 && x <= 8) begin
        req = 1'b1; a = 16; d = 12'hABC;
      end else begin
        req = ($urandom_range(0, 2) == 0);
        a   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(FB_W * FB_H, MEM_SZ - 1))
                                           : int'($urandom_range(0, FB_W * FB_H - 1));
        d   = 12'($urandom);
      end
      step(x, y, r, req, a, d);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_SZ; i++) begin
      ram[i]    = 12'($urandom);
      refRam[i] = ram[i];
    end
    ram[1]   = 12'hF00; refRam[1]   = 12'hF00;
    ram[160] = 12'h0F0; refRam[160] = 12'h0F0;
    expPix = '0; expAddr = '0; expWe = 1'b0; expWdata = '0; expFs = 1'b0;
    p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0; drops = 0;
    rst = 1'b0; posX = '0; posY = 9'd300; wrReq = 1'b0; wrAddr = '0; wrData = '0;
    repeat (3) @(posedge clk);

    runLine(3,   -1, -1, 0);
    runLine(4,   -1, -1, 0);
    runLine(0,   -1, -1, 0);
    runLine(5,    2,  4, 0);
    runLine(10,  -1, -1, 2);
    runLine(100, -1, -1, 0);
    runLine(478, -1, -1, 0);
    runLine(479, -1, -1, 0);
    runLine(490, -1, -1, 1);
    runLine(491, 100, 101, 1);
    runLine(511, -1, -1, 0);
    for (int k = 0; k < 3; k++) runLine(int'($urandom_range(0, 511)), -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
`default_nettype wire
